esp_cmd_frame_ctrl: RTL
=======================

// Module: esp_cmd_frame_ctrl
// PURPOSE
//  Sequences the byte stream from uart_rx (ESP32 link) into validated command frames.
//  Hunts for SOF, collects CMD, LEN, payload and XOR checksum, and enforces an inter-byte timeout.
//  Presents one decoded command per good frame to downstream register/LED logic.
//  Sits between uart_rx (rx_done_tick/dout) and the board control logic.
// PARAMETERS
//  SOF_BYTE     8'hA5    start-of-frame marker
//  MAX_LEN      4        max payload bytes (1..4); payload packs into frame_arg
//  TIMEOUT_CYC  1000000  clk cycles allowed between bytes inside a frame (10 ms at 100 MHz)
//  TO_W         20       width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  rx_valid     in   1   one-clk pulse, byte available (from uart_rx rx_done_tick)
//  rx_data      in   8   received byte; sampled only when rx_valid=1
//  frame_valid  out  1   one-clk pulse, good frame decoded
//  frame_cmd    out  8   CMD of last good frame (held)
//  frame_len    out  3   LEN of last good frame (held)
//  frame_arg    out  32  payload, byte0 in [7:0]; unused bytes are 0 (held)
//  err_pulse    out  1   one-clk pulse, frame rejected
//  err_code     out  2   01 checksum, 10 length, 11 timeout (held until next error)
//  err_cnt      out  8   rejected-frame count, saturates at 255
//  busy         out  1   1 while any state other than HUNT
// BEHAVIOUR
//  Reset (async): state=HUNT; all outputs 0; internal checksum, byte index and timer all 0.
//  Frame on wire: SOF, CMD, LEN, P0..P(LEN-1), CHK, where CHK = CMD ^ LEN ^ P0 ^ .. ^ P(LEN-1).
//  FSM advances only on rx_valid:
//   HUNT : byte==SOF -> CMD. Any other byte is dropped silently (no error).
//   CMD  : latch cmd, chk=byte -> LEN.
//   LEN  : byte>MAX_LEN -> length error, go to HUNT.
//          byte==0 -> CHK. Otherwise -> PAY with idx=0; chk^=byte.
//   PAY  : store byte at arg[8*idx+:8]; chk^=byte.
//          idx==LEN-1 -> CHK, else idx++.
//   CHK  : byte==chk -> go to HUNT and output the frame; else checksum error, go to HUNT.
//  Payload is built in a shadow register, cleared on SOF. frame_* update only on good frame.
//  Output timing: frame_valid/err_pulse are registered and assert the cycle after the deciding rx_valid.
//   Exactly one of the two fires per completed or aborted frame; never both.
//  Timeout: the timer clears on every rx_valid and on entry to HUNT, and counts clk while busy.
//   Timer reaching TIMEOUT_CYC-1 with rx_valid=0 -> timeout error, go to HUNT.
//   Simultaneous rx_valid at the limit: the byte wins and the timer clears.
//  A byte that aborts a frame (bad LEN/CHK) is consumed. It is not re-examined as a SOF.
//  SOF byte (0xA5) inside CMD/LEN/PAY/CHK is treated as data. No resync mid-frame.
//  err_cnt increments on every err_pulse and holds at 8'hFF.
//  Reset mid-frame: returns to HUNT immediately; a partial frame produces no pulse.
// STRUCTURE
//  Include file esp_frame_defs.vh:
//   - localparams for state encoding (HUNT, CMD, LEN, PAY, CHK)
//   - ERR_CHK=2'b01, ERR_LEN=2'b10, ERR_TO=2'b11
//   - default SOF_BYTE
//  Sub-module byte_timeout_timer (TIMEOUT_CYC, TO_W):
//   - inputs clr and en
//   - output expired
//  All else inline: one registered FSM plus datapath registers.
// TESTING
//  1 A5 10 02 34 12 34 -> one frame_valid; cmd=10, len=2, arg=00001234; err_pulse never asserts.
//  2 A5 10 02 34 12 35 -> err_pulse, err_code=01, err_cnt=1; frame_* unchanged.
//  3 A5 10 05 -> err_pulse, err_code=10 one cycle after LEN byte; then A5 20 00 20 -> frame_valid, cmd=20, len=0, arg=0.
//  4 A5 10 then idle TIMEOUT_CYC clks (use TIMEOUT_CYC=50) -> err_code=11, busy=0; next good frame accepted.
//  5 Garbage 00 FF 13 before frame 1 -> no err_pulse; frame decoded as in test 1.
//  6 Reset asserted after A5 10 02 34 -> outputs 0, no pulse; then frame 1 -> good decode.
//  Checks on all tests:
//   - frame_valid and err_pulse never both high
//   - each pulse is exactly 1 clk wide
//   - err_cnt saturates at 255 after 300 bad frames

Source files
------------

// File: rtl/esp_cmd_frame_ctrl_pkg.sv
// Shared definitions for the ESP32 command-frame controller: state encoding,
// error codes and the default start-of-frame marker.
package esp_cmd_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/esp_cmd_frame_ctrl_byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYC-1.
module byte_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count;

    // Clear has priority so a byte arriving exactly at the limit restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/esp_cmd_frame_ctrl.sv
// Frames the uart_rx byte stream into validated commands: SOF, CMD, LEN,
// payload, XOR checksum, with an inter-byte timeout.
module esp_cmd_frame_ctrl
    import esp_cmd_frame_ctrl_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE    = DEF_SOF_BYTE,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter int         TO_W        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        frame_valid,
    output logic [7:0]  frame_cmd,
    output logic [2:0]  frame_len,
    output logic [31:0] frame_arg,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state, state_n;
    logic [7:0]  cmd_q, chk_q;
    logic [2:0]  len_q;
    logic [1:0]  idx_q;
    logic [31:0] arg_q;
    logic        expired;

    logic        clr_shadow, load_cmd, load_len, store_pay, good, err;
    logic [1:0]  err_kind;

    assign busy = (state != ST_HUNT);

    byte_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (rx_valid || state == ST_HUNT),
        .en     (busy),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_HUNT;
        else       state <= state_n;
    end

    // A received byte always takes precedence over a timeout in the same cycle.
    always_comb begin
        state_n    = state;
        clr_shadow = 1'b0;
        load_cmd   = 1'b0;
        load_len   = 1'b0;
        store_pay  = 1'b0;
        good       = 1'b0;
        err        = 1'b0;
        err_kind   = ERR_CHK;
        if (rx_valid) begin
            case (state)
                ST_HUNT: begin
                    if (rx_data == SOF_BYTE) begin
                        clr_shadow = 1'b1;
                        state_n    = ST_CMD;
                    end
                end
                ST_CMD: begin
                    load_cmd = 1'b1;
                    state_n  = ST_LEN;
                end
                ST_LEN: begin
                    if (rx_data > MAX_LEN_B) begin
                        err      = 1'b1;
                        err_kind = ERR_LEN;
                        state_n  = ST_HUNT;
                    end else begin
                        load_len = 1'b1;
                        state_n  = (rx_data == 8'd0) ? ST_CHK : ST_PAY;
                    end
                end
                ST_PAY: begin
                    store_pay = 1'b1;
                    if ({1'b0, idx_q} == len_q - 3'd1) state_n = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data == chk_q) begin
                        good = 1'b1;
                    end else begin
                        err      = 1'b1;
                        err_kind = ERR_CHK;
                    end
                    state_n = ST_HUNT;
                end
                default: state_n = ST_HUNT;
            endcase
        end else if (busy && expired) begin
            err      = 1'b1;
            err_kind = ERR_TO;
            state_n  = ST_HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q <= '0;
            chk_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            arg_q <= '0;
        end else if (clr_shadow) begin
            cmd_q <= '0;
            chk_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            arg_q <= '0;
        end else if (load_cmd) begin
            cmd_q <= rx_data;
            chk_q <= rx_data;
        end else if (load_len) begin
            len_q <= rx_data[2:0];
            chk_q <= chk_q ^ rx_data;
            idx_q <= '0;
        end else if (store_pay) begin
            arg_q[{idx_q, 3'b000} +: 8] <= rx_data;
            chk_q <= chk_q ^ rx_data;
            idx_q <= idx_q + 2'd1;
        end
    end

    // Published frame fields and error status change only on a decided frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            frame_arg   <= '0;
            err_code    <= '0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= good;
            err_pulse   <= err;
            if (good) begin
                frame_cmd <= cmd_q;
                frame_len <= len_q;
                frame_arg <= arg_q;
            end
            if (err) begin
                err_code <= err_kind;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
